// File: rtl/rf_write_port_arbiter_if.sv
// rtl/rf_write_port_arbiter_if.sv - bus bundle between writeback/long-latency sources and the RF write port
//
// Purpose: groups the writeback request, the long-latency result handshake and
// the register-file write outputs so the arbiter takes a single bus port.
// Signals:
//   wb_reg_write, wb_dst, wb_data   writeback stage write request
//   lu_valid, lu_dst, lu_data       long-latency unit result offer
//   lu_ready                        arbiter accepts the lu_* result this cycle
//   rf_we, rf_waddr, rf_wdata       registered register-file write port
//   stall                           pipeline freeze request
//   buf_count                       long-latency FIFO occupancy
// Modports: master = pipeline/register-file side, slave = arbiter.
interface rf_write_port_arbiter_if;
  logic        wb_reg_write;
  logic [4:0]  wb_dst;
  logic [31:0] wb_data;
  logic        lu_valid;
  logic [4:0]  lu_dst;
  logic [31:0] lu_data;
  logic        lu_ready;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        stall;
  logic [3:0]  buf_count;

  modport master (
    output wb_reg_write, wb_dst, wb_data, lu_valid, lu_dst, lu_data,
    input  lu_ready, rf_we, rf_waddr, rf_wdata, stall, buf_count
  );

  modport slave (
    input  wb_reg_write, wb_dst, wb_data, lu_valid, lu_dst, lu_data,
    output lu_ready, rf_we, rf_waddr, rf_wdata, stall, buf_count
  );
endinterface

// File: rtl/rf_write_port_arbiter.sv
// rtl/rf_write_port_arbiter.sv - shares the RF write port between writeback and a long-latency unit
//
// Purpose: writeback owns the write port by priority; long-latency results are
// buffered in a small FIFO and drain into idle cycles. When the FIFO head has
// waited STARVE_LIMIT cycles the block raises stall for one cycle and forces
// the head out, ignoring that cycle's writeback request.
// Ports:
//   clock    system clock, rising edge
//   reset_n  asynchronous active-low reset
//   bus      rf_write_port_arbiter_if.slave (writeback, long-latency and RF signals)
module rf_write_port_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input logic                    clock,
  input logic                    reset_n,
  rf_write_port_arbiter_if.slave bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [4:0]    dst_mem  [DEPTH];
  logic [31:0]   data_mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [3:0]    count;
  logic [3:0]    wait_cnt;

  logic          rf_we_q;
  logic [4:0]    rf_waddr_q;
  logic [31:0]   rf_wdata_q;

  logic          empty;
  logic          full;
  logic          wb_req;
  logic          push;
  logic          accept;
  logic          pop;
  logic          stall_c;
  logic [4:0]    head_dst;
  logic [31:0]   head_data;

  always_comb begin
    empty     = (count == 4'd0);
    full      = (count == 4'(DEPTH));
    // ready depends only on registered occupancy: no push-through when full
    accept    = bus.lu_valid && !full;
    // results for $0 are accepted but never stored
    push      = accept && (bus.lu_dst != 5'd0);
    wb_req    = bus.wb_reg_write && (bus.wb_dst != 5'd0);
    stall_c   = (wait_cnt == 4'(STARVE_LIMIT)) && !empty;
    // forced pop on stall, otherwise only when writeback leaves the port idle;
    // head comes from registered state so a same-cycle push is never popped
    pop       = !empty && (stall_c || !wb_req);
    head_dst  = dst_mem[rd_ptr];
    head_data = data_mem[rd_ptr];
  end

  // payload storage needs no reset: occupancy alone decides what is valid
  always_ff @(posedge clock) begin
    if (push) begin
      dst_mem[wr_ptr]  <= bus.lu_dst;
      data_mem[wr_ptr] <= bus.lu_data;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= 4'd0;
      wait_cnt   <= 4'd0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= 5'd0;
      rf_wdata_q <= 32'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;

      case ({push, pop})
        2'b10:   count <= count + 4'd1;
        2'b01:   count <= count - 4'd1;
        default: count <= count;
      endcase

      // counts cycles the current head has spent in the FIFO; an entry
      // arriving into an empty FIFO has waited one cycle after this edge
      if (pop || (empty && !push))
        wait_cnt <= 4'd0;
      else if (wait_cnt != 4'(STARVE_LIMIT))
        wait_cnt <= wait_cnt + 4'd1;

      if (pop) begin
        rf_we_q    <= 1'b1;
        rf_waddr_q <= head_dst;
        rf_wdata_q <= head_data;
      end else if (wb_req) begin
        rf_we_q    <= 1'b1;
        rf_waddr_q <= bus.wb_dst;
        rf_wdata_q <= bus.wb_data;
      end else begin
        rf_we_q    <= 1'b0;
      end
    end
  end

  assign bus.lu_ready  = !full;
  assign bus.stall     = stall_c;
  assign bus.buf_count = count;
  assign bus.rf_we     = rf_we_q;
  assign bus.rf_waddr  = rf_waddr_q;
  assign bus.rf_wdata  = rf_wdata_q;

endmodule

// File: tb/tb_rf_write_port_arbiter.sv
// tb/tb_rf_write_port_arbiter.sv - directed self-checking bench for rf_write_port_arbiter
module tb_rf_write_port_arbiter;

  logic clock;
  logic reset_n;
  int   checks;
  int   fails;

  rf_write_port_arbiter_if bus ();

  rf_write_port_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.wb_reg_write = 1'b0;
    bus.wb_dst       = 5'd0;
    bus.wb_data      = 32'd0;
    bus.lu_valid     = 1'b0;
    bus.lu_dst       = 5'd0;
    bus.lu_data      = 32'd0;
  endtask

  task automatic drive_wb(input logic [4:0] d, input logic [31:0] v);
    bus.wb_reg_write = 1'b1;
    bus.wb_dst       = d;
    bus.wb_data      = v;
  endtask

  task automatic drive_lu(input logic [4:0] d, input logic [31:0] v);
    bus.lu_valid = 1'b1;
    bus.lu_dst   = d;
    bus.lu_data  = v;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    drive_wb(5'd5, 32'h1111_1111);
    drive_lu(5'd9, 32'h2222_2222);
    step(); step(); step();
    checks++; if (bus.rf_we !== 1'b0) begin fails++; $display("FAIL reset_rf_we: got %b expected 0", bus.rf_we); end
    checks++; if (bus.rf_waddr !== 5'd0) begin fails++; $display("FAIL reset_rf_waddr: got %0d expected 0", bus.rf_waddr); end
    checks++; if (bus.rf_wdata !== 32'd0) begin fails++; $display("FAIL reset_rf_wdata: got %h expected 0", bus.rf_wdata); end
    checks++; if (bus.buf_count !== 4'd0) begin fails++; $display("FAIL reset_buf_count: got %0d expected 0", bus.buf_count); end
    checks++; if (bus.stall !== 1'b0) begin fails++; $display("FAIL reset_stall: got %b expected 0", bus.stall); end
    checks++; if (bus.lu_ready !== 1'b1) begin fails++; $display("FAIL reset_lu_ready: got %b expected 1", bus.lu_ready); end
    idle_inputs();
    reset_n = 1'b1;
    step();
    checks++; if (bus.rf_we !== 1'b0) begin fails++; $display("FAIL post_reset_rf_we: got %b expected 0", bus.rf_we); end
    checks++; if (bus.buf_count !== 4'd0) begin fails++; $display("FAIL post_reset_buf_count: got %0d expected 0", bus.buf_count); end
  endtask

  task automatic test_writeback_only();
    drive_wb(5'd5, 32'h1234_5678);
    step();
    checks++; if (bus.rf_we !== 1'b1) begin fails++; $display("FAIL wb_rf_we: got %b expected 1", bus.rf_we); end
    checks++; if (bus.rf_waddr !== 5'd5) begin fails++; $display("FAIL wb_rf_waddr: got %0d expected 5", bus.rf_waddr); end
    checks++; if (bus.rf_wdata !== 32'h1234_5678) begin fails++; $display("FAIL wb_rf_wdata: got %h expected 12345678", bus.rf_wdata); end
    idle_inputs();
    step();
    checks++; if (bus.rf_we !== 1'b0) begin fails++; $display("FAIL wb_idle_rf_we: got %b expected 0", bus.rf_we); end
    checks++; if (bus.rf_waddr !== 5'd5) begin fails++; $display("FAIL wb_hold_rf_waddr: got %0d expected 5", bus.rf_waddr); end
  endtask

  task automatic test_drain();
    drive_lu(5'd9, 32'hDEAD_BEEF);
    step();
    idle_inputs();
    checks++; if (bus.buf_count !== 4'd1) begin fails++; $display("FAIL drain_buf_count1: got %0d expected 1", bus.buf_count); end
    checks++; if (bus.rf_we !== 1'b0) begin fails++; $display("FAIL drain_early_rf_we: got %b expected 0", bus.rf_we); end
    step();
    checks++; if (bus.rf_we !== 1'b1) begin fails++; $display("FAIL drain_rf_we: got %b expected 1", bus.rf_we); end
    checks++; if (bus.rf_waddr !== 5'd9) begin fails++; $display("FAIL drain_rf_waddr: got %0d expected 9", bus.rf_waddr); end
    checks++; if (bus.rf_wdata !== 32'hDEAD_BEEF) begin fails++; $display("FAIL drain_rf_wdata: got %h expected deadbeef", bus.rf_wdata); end
    checks++; if (bus.buf_count !== 4'd0) begin fails++; $display("FAIL drain_buf_count0: got %0d expected 0", bus.buf_count); end
    step();
  endtask

  task automatic test_backpressure();
    drive_wb(5'd10, 32'hA0);
    drive_lu(5'd3, 32'h33);
    step();
    checks++; if (bus.buf_count !== 4'd1) begin fails++; $display("FAIL bp_buf_count1: got %0d expected 1", bus.buf_count); end
    checks++; if (bus.rf_waddr !== 5'd10) begin fails++; $display("FAIL bp_wb_first: got %0d expected 10", bus.rf_waddr); end
    drive_wb(5'd11, 32'hA1);
    drive_lu(5'd4, 32'h44);
    step();
    checks++; if (bus.buf_count !== 4'd2) begin fails++; $display("FAIL bp_buf_count2: got %0d expected 2", bus.buf_count); end
    checks++; if (bus.lu_ready !== 1'b0) begin fails++; $display("FAIL bp_lu_ready_full: got %b expected 0", bus.lu_ready); end
    drive_wb(5'd12, 32'hA2);
    drive_lu(5'd5, 32'h55);
    step();
    checks++; if (bus.buf_count !== 4'd2) begin fails++; $display("FAIL bp_third_rejected: got %0d expected 2", bus.buf_count); end
    checks++; if (bus.rf_waddr !== 5'd12) begin fails++; $display("FAIL bp_wb_third: got %0d expected 12", bus.rf_waddr); end
    checks++; if (bus.stall !== 1'b0) begin fails++; $display("FAIL bp_no_stall: got %b expected 0", bus.stall); end
    idle_inputs();
    step();
    checks++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd3 || bus.rf_wdata !== 32'h33) begin fails++; $display("FAIL bp_drain_first: got we=%b addr=%0d data=%h expected we=1 addr=3 data=33", bus.rf_we, bus.rf_waddr, bus.rf_wdata); end
    step();
    checks++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd4 || bus.rf_wdata !== 32'h44) begin fails++; $display("FAIL bp_drain_second: got we=%b addr=%0d data=%h expected we=1 addr=4 data=44", bus.rf_we, bus.rf_waddr, bus.rf_wdata); end
    checks++; if (bus.lu_ready !== 1'b1) begin fails++; $display("FAIL bp_lu_ready_again: got %b expected 1", bus.lu_ready); end
    step();
    checks++; if (bus.rf_we !== 1'b0) begin fails++; $display("FAIL bp_no_extra_write: got %b expected 0", bus.rf_we); end
  endtask

  task automatic test_starvation();
    drive_wb(5'd20, 32'hB0);
    drive_lu(5'd7, 32'h77);
    step();
    bus.lu_valid = 1'b0;
    checks++; if (bus.stall !== 1'b0) begin fails++; $display("FAIL starve_stall_c1: got %b expected 0", bus.stall); end
    drive_wb(5'd21, 32'hB1);
    step();
    checks++; if (bus.stall !== 1'b0) begin fails++; $display("FAIL starve_stall_c2: got %b expected 0", bus.stall); end
    drive_wb(5'd22, 32'hB2);
    step();
    checks++; if (bus.stall !== 1'b0) begin fails++; $display("FAIL starve_stall_c3: got %b expected 0", bus.stall); end
    checks++; if (bus.rf_waddr !== 5'd22) begin fails++; $display("FAIL starve_wb_c3: got %0d expected 22", bus.rf_waddr); end
    drive_wb(5'd23, 32'hB3);
    step();
    checks++; if (bus.stall !== 1'b1) begin fails++; $display("FAIL starve_stall_c4: got %b expected 1", bus.stall); end
    checks++; if (bus.rf_waddr !== 5'd23) begin fails++; $display("FAIL starve_wb_c4: got %0d expected 23", bus.rf_waddr); end
    drive_wb(5'd24, 32'hB4);
    step();
    checks++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd7 || bus.rf_wdata !== 32'h77) begin fails++; $display("FAIL starve_forced_pop: got we=%b addr=%0d data=%h expected we=1 addr=7 data=77", bus.rf_we, bus.rf_waddr, bus.rf_wdata); end
    checks++; if (bus.stall !== 1'b0) begin fails++; $display("FAIL starve_stall_clear: got %b expected 0", bus.stall); end
    checks++; if (bus.buf_count !== 4'd0) begin fails++; $display("FAIL starve_buf_count: got %0d expected 0", bus.buf_count); end
    step();
    checks++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd24 || bus.rf_wdata !== 32'hB4) begin fails++; $display("FAIL starve_held_wb: got we=%b addr=%0d data=%h expected we=1 addr=24 data=b4", bus.rf_we, bus.rf_waddr, bus.rf_wdata); end
    idle_inputs();
    step();
  endtask

  task automatic test_zero_and_reset();
    drive_lu(5'd0, 32'hCAFE);
    checks++; if (bus.lu_ready !== 1'b1) begin fails++; $display("FAIL zero_lu_ready: got %b expected 1", bus.lu_ready); end
    step();
    checks++; if (bus.buf_count !== 4'd0) begin fails++; $display("FAIL zero_dropped: got %0d expected 0", bus.buf_count); end
    checks++; if (bus.rf_we !== 1'b0) begin fails++; $display("FAIL zero_no_write: got %b expected 0", bus.rf_we); end
    drive_lu(5'd8, 32'h88);
    step();
    bus.lu_valid = 1'b0;
    drive_wb(5'd0, 32'hFFFF);
    step();
    checks++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd8 || bus.rf_wdata !== 32'h88) begin fails++; $display("FAIL zero_wb_yields: got we=%b addr=%0d data=%h expected we=1 addr=8 data=88", bus.rf_we, bus.rf_waddr, bus.rf_wdata); end
    drive_wb(5'd15, 32'hF0);
    drive_lu(5'd1, 32'h11);
    step();
    drive_lu(5'd2, 32'h22);
    step();
    checks++; if (bus.buf_count !== 4'd2) begin fails++; $display("FAIL mid_reset_pre_count: got %0d expected 2", bus.buf_count); end
    idle_inputs();
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (bus.buf_count !== 4'd0) begin fails++; $display("FAIL mid_reset_buf_count: got %0d expected 0", bus.buf_count); end
    checks++; if (bus.rf_we !== 1'b0) begin fails++; $display("FAIL mid_reset_rf_we: got %b expected 0", bus.rf_we); end
    checks++; if (bus.lu_ready !== 1'b1) begin fails++; $display("FAIL mid_reset_lu_ready: got %b expected 1", bus.lu_ready); end
    step();
    reset_n = 1'b1;
    step();
    checks++; if (bus.rf_we !== 1'b0) begin fails++; $display("FAIL mid_reset_no_drain: got %b expected 0", bus.rf_we); end
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    idle_inputs();
    reset_n = 1'b0;
    test_reset();
    test_writeback_only();
    test_drain();
    test_backpressure();
    test_starvation();
    test_zero_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/rf_write_port_arbiter.md
Name: rf_write_port_arbiter

Overview:
- Shares the single register-file write port between the in-order writeback stage and a long-latency unit (multi-cycle multiply/divide) that returns results out of band.
- Writeback has priority. Long-latency results are buffered in a small FIFO and drain into idle write-port cycles.
- A starvation counter freezes the pipeline so a buffered result is guaranteed to commit.
- Sits between the writeback stage outputs and the register file write inputs.

Parameters:
- DEPTH, 2, number of long-latency result entries buffered (power of two, 2..8).
- STARVE_LIMIT, 4, cycles the FIFO head may wait before the block forces a pipeline stall (1..15).

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous active-low reset.
- wb_reg_write  input  1  writeback stage requests a register write this cycle.
- wb_dst  input  5  writeback destination register.
- wb_data  input  32  writeback data (already muxed ALU/memory).
- lu_valid  input  1  long-latency unit presents a result.
- lu_dst  input  5  long-latency result destination.
- lu_data  input  32  long-latency result data.
- lu_ready  output  1  block accepts lu_* this cycle.
- rf_we  output  1  register-file write enable (registered).
- rf_waddr  output  5  register-file write address (registered).
- rf_wdata  output  32  register-file write data (registered).
- stall  output  1  pipeline must freeze; the writeback request is held and ignored this cycle.
- buf_count  output  4  current FIFO occupancy, 0..DEPTH.

Behaviour:
Reset (asynchronous, reset_n=0):
- rf_we=0, rf_waddr=0, rf_wdata=0.
- FIFO empty, buf_count=0, wait counter=0.
- stall=0, lu_ready=1.
- Reset mid-operation discards all buffered entries; the system accepts that loss.

lu_ready:
- lu_ready = (buf_count < DEPTH), from registered state only.
- No same-cycle push-through when full, even if a pop occurs.

Push (lu_valid & lu_ready):
- If lu_dst != 0, the entry is enqueued at the tail; buf_count increments at the edge unless a pop coincides.
- If lu_dst == 0, the result is accepted and dropped; no enqueue.

Grant logic (combinational, registered into rf_*), evaluated each cycle with priority:
1. stall=1 and FIFO non-empty: pop head; rf_we<=1, rf_waddr<=head dst, rf_wdata<=head data. The writeback request is ignored; the pipeline re-presents it next cycle.
2. wb_reg_write=1 and wb_dst != 0: rf_we<=1, rf_waddr<=wb_dst, rf_wdata<=wb_data.
3. FIFO non-empty: pop head; rf_we<=1 with head values.
4. Otherwise: rf_we<=0; rf_waddr and rf_wdata hold their values.

Writes to $0:
- wb_reg_write with wb_dst=0 counts as no request; rule 3 may use the cycle.

Latency:
- Writeback sampled at edge k: rf_we=1 after edge k.
- Long-latency result accepted at edge k: earliest rf_we=1 after edge k+1.

Wait counter (4 bits):
- Cleared when the FIFO is empty or a pop occurs at the edge.
- Otherwise increments, saturating at STARVE_LIMIT.
- stall = (wait counter == STARVE_LIMIT) & FIFO non-empty.
- stall lasts exactly one cycle per forced pop.

Simultaneous push and pop:
- Legal when not full; buf_count is unchanged.
- A pushed entry is never popped in the same cycle.

Ordering:
- FIFO entries commit in arrival order.
- Write-after-write ordering between writeback and long-latency results is the issue scoreboard's responsibility, not this block's.

Test Plan:
- Reset: hold reset_n=0 over 3 edges with traffic present -> rf_we=0, rf_waddr=0, rf_wdata=0, buf_count=0, stall=0, lu_ready=1; deassert -> no spurious write.
- Writeback only: wb_reg_write=1, wb_dst=5, wb_data=0x1234_5678 at edge 1 -> after edge 1 rf_we=1, rf_waddr=5, rf_wdata=0x12345678; wb_reg_write=0 -> rf_we=0 next cycle.
- Drain: lu_valid=1, lu_dst=9, lu_data=0xDEAD_BEEF at edge 1 with writeback idle -> buf_count=1 after edge 1; rf_we=1, rf_waddr=9 after edge 2; buf_count=0.
- Backpressure (DEPTH=2): two pushes (dst 3, 4) while writeback writes every cycle -> buf_count=2, lu_ready=0; third lu_valid is not accepted; writeback stops -> dst 3 then dst 4 commit on consecutive cycles, lu_ready=1 again.
- Starvation (STARVE_LIMIT=4): one push (dst 7) then continuous writeback writes -> stall=1 in the 4th cycle after enqueue; that edge writes dst 7 and suppresses writeback; stall=0 next cycle and the held writeback commits.
- $0 and reset mid-operation: lu_dst=0 push -> lu_ready=1, buf_count stays 0; wb_dst=0 with FIFO entry pending -> FIFO entry commits that cycle; assert reset_n with buf_count=2 -> buf_count=0 immediately, rf_we=0.
